// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 encodings and types for axi4_master_bridge.
//   burst_e  : AXI burst type encodings
//   resp_e   : AXI response encodings
//   state_e  : bridge FSM states
//   size_e   : AXI size codes supported on a 32-bit data bus
//   req_t    : request fields captured when a request is accepted
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WADDR,
    ST_WRESP
  } state_e;

  typedef enum logic [2:0] {
    SIZE_1B = 3'd0,
    SIZE_2B = 3'd1,
    SIZE_4B = 3'd2
  } size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  size;
    logic [7:0]  len;
    logic        wrap;
  } req_t;

  // AXI only allows WRAP bursts of 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_master_bridge.sv
// axi4_master_bridge: single-outstanding core request -> AXI4 master bridge.
//   clock/reset     : clock, synchronous active-high reset
//   req_*           : core request (valid/ready, wen, addr, wdata, wstrb,
//                     size, len (reads only), wrap)
//   resp_*          : one-cycle pulse per read beat / write completion,
//                     with rdata, last and err
//   io_master_*     : AXI4 master AR/R/AW/W/B channels
// Optional: define AXI_BRIDGE_ERRCHK_EN to flag bad rresp/bresp, mismatched
// rid/bid and misplaced rlast on resp_err; otherwise resp_err is tied 0.
module axi4_master_bridge
  import axi4_pkg::*;
#(
  parameter logic [3:0] ID     = 4'h0,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [2:0]          req_size,
  input  logic [7:0]          req_len,
  input  logic                req_wrap,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_last,
  output logic                resp_err,
  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [3:0]          io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  output logic                io_master_rready,
  input  logic                io_master_rvalid,
  input  logic [1:0]          io_master_rresp,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic                io_master_rlast,
  input  logic [3:0]          io_master_rid,
  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [3:0]          io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  output logic                io_master_bready,
  input  logic                io_master_bvalid,
  input  logic [1:0]          io_master_bresp,
  input  logic [3:0]          io_master_bid
);

  state_e state;
  req_t   req_q;
  logic   aw_done, w_done;

  wire aw_hs = io_master_awvalid & io_master_awready;
  wire w_hs  = io_master_wvalid  & io_master_wready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= ST_IDLE;
      req_q             <= '0;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      io_master_arvalid <= 1'b0;
      io_master_rready  <= 1'b0;
      io_master_awvalid <= 1'b0;
      io_master_wvalid  <= 1'b0;
      io_master_bready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          req_q.addr  <= req_addr;
          req_q.wdata <= req_wdata;
          req_q.wstrb <= req_wstrb;
          // The bus is 32 bits wide; an oversized code is clamped to a word.
          req_q.size  <= (req_size > SIZE_4B) ? SIZE_4B : req_size;
          req_q.len   <= req_len;
          req_q.wrap  <= req_wrap;
          if (req_wen) begin
            state             <= ST_WADDR;
            io_master_awvalid <= 1'b1;
            io_master_wvalid  <= 1'b1;
            aw_done           <= 1'b0;
            w_done            <= 1'b0;
          end else begin
            state             <= ST_RADDR;
            io_master_arvalid <= 1'b1;
          end
        end
        ST_RADDR: if (io_master_arready) begin
          io_master_arvalid <= 1'b0;
          io_master_rready  <= 1'b1;
          state             <= ST_RDATA;
        end
        // rlast ends the burst even if it arrives early.
        ST_RDATA: if (io_master_rvalid && io_master_rlast) begin
          io_master_rready <= 1'b0;
          state            <= ST_IDLE;
        end
        ST_WADDR: begin
          if (aw_hs) begin
            io_master_awvalid <= 1'b0;
            aw_done           <= 1'b1;
          end
          if (w_hs) begin
            io_master_wvalid <= 1'b0;
            w_done           <= 1'b1;
          end
          // Covers both channels completing in the same cycle.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            io_master_bready <= 1'b1;
            state            <= ST_WRESP;
          end
        end
        ST_WRESP: if (io_master_bvalid) begin
          io_master_bready <= 1'b0;
          state            <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);

  wire r_beat = (state == ST_RDATA) & io_master_rvalid;
  wire b_beat = (state == ST_WRESP) & io_master_bvalid;

  assign resp_valid = r_beat | b_beat;
  assign resp_rdata = io_master_rdata;
  assign resp_last  = (r_beat & io_master_rlast) | b_beat;

  assign io_master_araddr  = req_q.addr;
  assign io_master_arid    = ID;
  assign io_master_arlen   = req_q.len;
  assign io_master_arsize  = req_q.size;
  // An illegal WRAP length silently degrades to INCR.
  assign io_master_arburst = (req_q.wrap && wrap_len_ok(req_q.len)) ? BURST_WRAP : BURST_INCR;

  assign io_master_awaddr  = req_q.addr;
  assign io_master_awid    = ID;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = req_q.size;
  assign io_master_awburst = BURST_INCR;
  assign io_master_wdata   = req_q.wdata;
  assign io_master_wstrb   = req_q.wstrb;
  assign io_master_wlast   = 1'b1;

`ifdef AXI_BRIDGE_ERRCHK_EN
  // Beats remaining after the current one; rlast must coincide with zero.
  logic [7:0] beat_cnt;

  always_ff @(posedge clock) begin
    if (reset)                                      beat_cnt <= '0;
    else if (state == ST_RADDR && io_master_arready) beat_cnt <= req_q.len;
    else if (r_beat)                                beat_cnt <= beat_cnt - 8'd1;
  end

  wire r_err = (io_master_rresp != RESP_OKAY) | (io_master_rid != ID) |
               (io_master_rlast != (beat_cnt == 8'd0));
  wire b_err = (io_master_bresp != RESP_OKAY) | (io_master_bid != ID);

  assign resp_err = (r_beat & r_err) | (b_beat & b_err);
`else
  assign resp_err = 1'b0;
  wire unused_err_inputs = ^{io_master_rresp, io_master_rid, io_master_bresp, io_master_bid};
`endif

endmodule

// File: tb/tb_axi4_master_bridge.sv
// tb_axi4_master_bridge: directed self-checking bench for axi4_master_bridge.
// The bench acts as the AXI slave, driving and sampling on the falling edge.
module tb_axi4_master_bridge;

`ifdef AXI_BRIDGE_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_wrap;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_size;
  logic [7:0]  req_len;
  logic        resp_valid, resp_last, resp_err;
  logic [31:0] resp_rdata;
  logic        arvalid, arready, rready, rvalid, rlast;
  logic [31:0] araddr, rdata;
  logic [3:0]  arid, rid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bready, bvalid;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awid, wstrb, bid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  axi4_master_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_size(req_size), .req_len(req_len), .req_wrap(req_wrap),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_last(resp_last),
    .resp_err(resp_err),
    .io_master_arvalid(arvalid), .io_master_arready(arready),
    .io_master_araddr(araddr), .io_master_arid(arid), .io_master_arlen(arlen),
    .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_rready(rready), .io_master_rvalid(rvalid),
    .io_master_rresp(rresp), .io_master_rdata(rdata),
    .io_master_rlast(rlast), .io_master_rid(rid),
    .io_master_awvalid(awvalid), .io_master_awready(awready),
    .io_master_awaddr(awaddr), .io_master_awid(awid), .io_master_awlen(awlen),
    .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready),
    .io_master_wdata(wdata), .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bready(bready), .io_master_bvalid(bvalid),
    .io_master_bresp(bresp), .io_master_bid(bid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read with ar_stall cycles of arready low; rlast on beat index last_at.
  task automatic read_txn(input logic [31:0] addr, input logic [7:0] len,
                          input logic wrap, input logic [1:0] exp_burst,
                          input int last_at, input int ar_stall,
                          input logic [31:0] base);
    chk("rd_req_ready_idle", req_ready, 1);
    req_valid = 1; req_wen = 0; req_addr = addr; req_len = len;
    req_size = 3'd2; req_wrap = wrap;
    arready = (ar_stall == 0);
    @(negedge clock);
    req_valid = 0;
    for (int k = 0; k <= ar_stall; k++) begin
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, addr);
      chk("arlen", arlen, len);
      chk("arburst", arburst, exp_burst);
      chk("arsize_arid", {arsize, arid}, {3'd2, 4'h0});
      chk("rd_req_ready_busy", req_ready, 0);
      chk("rd_no_resp", resp_valid, 0);
      if (k == ar_stall) arready = 1;
      @(negedge clock);
    end
    arready = 0;
    chk("arvalid_drop", arvalid, 0);
    for (int b = 0; b <= last_at; b++) begin
      chk("rready", rready, 1);
      rvalid = 1; rdata = base + 32'(b); rlast = (b == last_at); rresp = 2'b00; rid = 4'h0;
      #1;
      chk("r_resp_valid", resp_valid, 1);
      chk("r_resp_rdata", resp_rdata, base + 32'(b));
      chk("r_resp_last", resp_last, (b == last_at));
      chk("r_resp_err", resp_err, ERRCHK && (b == last_at) && (last_at != int'(len)));
      @(negedge clock);
    end
    rvalid = 0; rlast = 0;
    #1;
    chk("rd_done_ready", req_ready, 1);
    chk("rd_done_rready", rready, 0);
    chk("rd_done_resp", resp_valid, 0);
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_stall,
                           input int w_stall, input logic [1:0] resp,
                           input logic exp_err);
    int mx;
    mx = (aw_stall > w_stall) ? aw_stall : w_stall;
    chk("wr_req_ready_idle", req_ready, 1);
    req_valid = 1; req_wen = 1; req_addr = addr; req_wdata = data;
    req_wstrb = strb; req_size = 3'd2; req_len = 8'd5; req_wrap = 0;
    @(negedge clock);
    req_valid = 0;
    for (int c = 0; c <= mx; c++) begin
      chk("awvalid", awvalid, (c <= aw_stall));
      chk("wvalid", wvalid, (c <= w_stall));
      if (c <= aw_stall) chk("awaddr", awaddr, addr);
      if (c <= w_stall) chk("wdata_wstrb", {wdata, wstrb}, {data, strb});
      chk("aw_fixed", {awlen, awburst, wlast, awid}, {8'd0, 2'b01, 1'b1, 4'h0});
      chk("bready_early", bready, 0);
      chk("wr_no_resp", resp_valid, 0);
      awready = (c >= aw_stall);
      wready  = (c >= w_stall);
      @(negedge clock);
    end
    awready = 0; wready = 0;
    chk("bready", bready, 1);
    chk("aw_w_idle", {awvalid, wvalid}, 2'b00);
    bvalid = 1; bresp = resp; bid = 4'h0;
    #1;
    chk("b_resp_valid", resp_valid, 1);
    chk("b_resp_last", resp_last, 1);
    chk("b_resp_err", resp_err, exp_err);
    @(negedge clock);
    bvalid = 0; bresp = 0;
    #1;
    chk("wr_done_ready", req_ready, 1);
    chk("wr_done_resp", resp_valid, 0);
    chk("wr_done_bready", bready, 0);
  endtask

  initial begin
    reset = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
    req_wstrb = 0; req_size = 0; req_len = 0; req_wrap = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0; rlast = 0; rid = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    repeat (2) @(negedge clock);
    chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_err", resp_err, 0);
    reset = 0;
    @(negedge clock);

    // Single-beat read, zero-wait slave.
    read_txn(32'h8000_0004, 8'd0, 1'b0, 2'b01, 0, 0, 32'hDEAD_BEEF);
    // Legal WRAP burst of 4 beats, then illegal WRAP length degrades to INCR.
    read_txn(32'h8000_000C, 8'd3, 1'b1, 2'b10, 3, 0, 32'h1000_0000);
    read_txn(32'h8000_0010, 8'd2, 1'b1, 2'b01, 2, 0, 32'h2000_0000);
    read_txn(32'h8000_0020, 8'd7, 1'b1, 2'b10, 7, 0, 32'h3000_0000);
    // AR backpressure: arready low for 5 cycles.
    read_txn(32'h8000_0040, 8'd1, 1'b0, 2'b01, 1, 5, 32'h4000_0000);

    // Write: awready low 3 cycles, W handshakes first.
    write_txn(32'hA000_03F8, 32'h41, 4'b0001, 3, 0, 2'b00, 1'b0);
    // Simultaneous AW/W handshake, zero wait.
    write_txn(32'hA000_0100, 32'h1234_5678, 4'b1111, 0, 0, 2'b00, 1'b0);
    // W stalled, AW first.
    write_txn(32'hA000_0200, 32'hCAFE_F00D, 4'b1100, 0, 2, 2'b00, 1'b0);
    // SLVERR on B.
    write_txn(32'hA000_0300, 32'h5, 4'b0010, 0, 0, 2'b10, ERRCHK);
    // Premature rlast on beat 2 of a 4-beat burst still ends the burst.
    read_txn(32'h8000_0080, 8'd3, 1'b0, 2'b01, 1, 0, 32'h5000_0000);

    // Reset during beat 2 of a 4-beat burst.
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0100; req_len = 8'd3;
    req_size = 3'd2; req_wrap = 0; arready = 1;
    @(negedge clock);
    req_valid = 0;
    @(negedge clock);
    arready = 0;
    rvalid = 1; rdata = 32'h1; rlast = 0;
    @(negedge clock);
    rdata = 32'h2; reset = 1;
    @(negedge clock);
    rvalid = 0; reset = 0;
    #1;
    chk("midrst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp", resp_valid, 0);
    @(negedge clock);
    read_txn(32'h8000_0200, 8'd1, 1'b0, 2'b01, 1, 0, 32'h6000_0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_master_bridge.md
Name: axi4_master_bridge

Overview:
Converts the core's simple single-outstanding memory request interface (IFU refill / LSU) into AXI4 master transactions on the io_master_* bus. It drives the bus toward the external memory/SoC slave. Supports single-beat and INCR/WRAP burst reads for cache-line refill, and single-beat writes with byte strobes. Only one transaction is outstanding at a time.

Parameters:
ID, 4'h0, constant value driven on arid/awid
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; wstrb is DATA_W/8)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  bridge idle and able to accept a request
req_wen  in  1  1 = write, 0 = read
req_addr  in  32  byte address
req_wdata  in  32  write data
req_wstrb  in  4  write byte mask
req_size  in  3  AXI size code, 0..2
req_len  in  8  beats-1; reads only
req_wrap  in  1  1 = WRAP burst, 0 = INCR burst
resp_valid  out  1  one-cycle pulse per read beat or write completion
resp_rdata  out  32  read beat data
resp_last  out  1  final beat or write completion
resp_err  out  1  error flag (see Optional Feature)
io_master_ar*/r*/aw*/w*/b*  per AXI4  master side: valid/addr/id/len/size/burst, ready/valid/resp/data/last/id; widths 32/4/8/3/2/1

Behaviour:
- Reset values: all bus valids 0, rready 0, bready 0, resp_valid 0, req_ready 1, state IDLE.
- Reset asserted mid-transaction returns to IDLE on the next edge. In-flight bus beats are dropped; the slave is reset by the same signal.
- States: IDLE, RADDR, RDATA, WADDR, WRESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch all req fields.
  - Go to RADDR if req_wen=0, else WADDR.
- RADDR:
  - arvalid=1 with araddr, arlen=req_len, arsize=req_size, arid=ID.
  - arburst=2'b10 if req_wrap and req_len in {1,3,7,15}; else 2'b01. An illegal WRAP request silently degrades to INCR.
  - AR signals stay stable until arready.
  - On handshake, go to RDATA.
- RDATA:
  - rready=1 continuously; resp has no backpressure.
  - resp_valid=rvalid, resp_rdata=rdata, resp_last=rlast (combinational).
  - On rvalid&rlast, go to IDLE.
  - An 8-bit beat counter loads req_len and decrements per beat.
- WADDR:
  - awvalid and wvalid both assert on entry. awlen=0, awburst=01, wlast=1.
  - Each valid drops independently after its own handshake; track aw_done and w_done.
  - When both are done (including a simultaneous handshake), go to WRESP.
  - req_len is ignored for writes.
- WRESP:
  - bready=1.
  - On bvalid, resp_valid=1, resp_last=1, then go to IDLE.
- Latency with a zero-wait slave:
  - Read: request accepted cycle 0, AR handshake cycle 1, first resp_valid cycle 2.
  - Write: AW/W handshake cycle 1, B cycle 2.
  - req_ready returns high the cycle after the last beat or B.
- rid/bid are ignored; the single outstanding transaction makes them redundant.

Optional Feature:
Macro AXI_BRIDGE_ERRCHK_EN.
- Defined: resp_err=1 alongside resp_valid when any of the following holds:
  - rresp/bresp is nonzero.
  - rid/bid is not equal to ID.
  - rlast does not coincide with the beat counter reaching 0; flagged on the offending beat.
  - A premature rlast still ends the burst.
- Undefined: resp_err tied 0 and the beat counter is removed.

Decomposition:
- Package axi4_pkg holds:
  - burst enum (FIXED=2'b00, INCR=2'b01, WRAP=2'b10);
  - resp enum (OKAY, EXOKAY, SLVERR, DECERR);
  - state enum;
  - size constants.
- No sub-module is needed; read and write paths share one FSM.

Test Plan:
- Single read: read addr 0x80000004, len 0, zero-wait slave returns 0xDEADBEEF → araddr=0x80000004, arlen=0; resp_valid at cycle 2 with rdata 0xDEADBEEF, resp_last=1; req_ready=1 at cycle 3.
- Wrap burst: read addr 0x8000000C, len 3, size 2, req_wrap=1 → arburst=10; 4 resp pulses, last on beat 4; a len 2 wrap request produces arburst=01.
- Split write: write 0xA00003F8, data 0x41, strb 0001; slave awready low 3 cycles, wready high → W handshake first, awvalid held stable 3 cycles; bready only after both handshakes; single completion pulse.
- Backpressure: arready low 5 cycles → arvalid and araddr stable all 5 cycles; no resp_valid; req_ready stays 0.
- Error (ERRCHK_EN): bresp=SLVERR → resp_err=1 with the completion pulse; a burst with len 3 but rlast on beat 2 → resp_err on beat 2, FSM back to IDLE.
- Reset mid-burst: assert reset during beat 2 of 4 → next cycle all valids 0, req_ready 1; a fresh read afterwards completes correctly.
